// File: rtl/pipe_stage_chain.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_chain                                             |
// | Description : Parametrised multi-stage pipeline register carrying a        |
// |               payload bus and a control bus through STAGES registers.      |
// |               Each stage has its own valid bit and supports global         |
// |               stall, flush and optional bubble collapse under stall.       |
// |               Optional feature macro: PIPE_STAGE_CHAIN_STALL_CNT_EN        |
// |               (adds the 16-bit saturating stall_cnt_o output).             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stage_chain #(
    parameter int PAYLOAD_W = 32,
    parameter int CTRL_W    = 4,
    parameter int STAGES    = 1,
    parameter int COLLAPSE  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic [CTRL_W-1:0]    ctrl_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    output logic                 ready_o,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] payload_o,
`ifdef PIPE_STAGE_CHAIN_STALL_CNT_EN
    output logic [CTRL_W-1:0]    ctrl_o,
    output logic [15:0]          stall_cnt_o
`else
    output logic [CTRL_W-1:0]    ctrl_o
`endif
);

    localparam bit c_collapse = (COLLAPSE != 0);

    // Reject illegal depths while the design is being elaborated.
    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("pipe_stage_chain: STAGES must be in 1..4, got %0d", STAGES);
        end
    endgenerate

    // Per-stage state, gathered into flat views so neighbours can see each other.
    logic [STAGES-1:0]    w_valid;
    logic [PAYLOAD_W-1:0] w_payload [STAGES];
    logic [CTRL_W-1:0]    w_ctrl    [STAGES];
    logic [STAGES-1:0]    w_mv;

    // Move enables, resolved from the output stage back towards the input so
    // that a stage only advances when the slot it moves into is being vacated
    // or is empty (collapse mode).
    always_comb begin : p_move
        logic w_chain;
        w_mv               = '0;
        w_chain            = ~stall_i;
        w_mv[STAGES-1]     = w_chain;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_chain = ~stall_i | (c_collapse & (~w_valid[k] | w_chain));
            w_mv[k] = w_chain;
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic                 w_in_valid;
            logic [PAYLOAD_W-1:0] w_in_payload;
            logic [CTRL_W-1:0]    w_in_ctrl;
            logic                 r_valid;
            logic [PAYLOAD_W-1:0] r_payload;
            logic [CTRL_W-1:0]    r_ctrl;

            if (k == 0) begin : g_head
                // A bubble entering the chain never carries live control bits.
                assign w_in_valid   = valid_i;
                assign w_in_payload = payload_i;
                assign w_in_ctrl    = valid_i ? ctrl_i : '0;
            end else begin : g_body
                assign w_in_valid   = w_valid[k-1];
                assign w_in_payload = w_payload[k-1];
                assign w_in_ctrl    = w_ctrl[k-1];
            end

            // Stage register: reset clears everything, flush kills valid and
            // control but leaves the payload untouched, otherwise load on move.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_valid   <= 1'b0;
                    r_payload <= '0;
                    r_ctrl    <= '0;
                end else if (flush_i) begin
                    r_valid   <= 1'b0;
                    r_ctrl    <= '0;
                end else if (w_mv[k]) begin
                    r_valid   <= w_in_valid;
                    r_payload <= w_in_payload;
                    r_ctrl    <= w_in_ctrl;
                end
            end

            assign w_valid[k]   = r_valid;
            assign w_payload[k] = r_payload;
            assign w_ctrl[k]    = r_ctrl;
        end
    endgenerate

    assign ready_o   = w_mv[0] & ~flush_i;
    assign valid_o   = w_valid[STAGES-1];
    assign payload_o = w_payload[STAGES-1];
    assign ctrl_o    = w_valid[STAGES-1] ? w_ctrl[STAGES-1] : '0;

`ifdef PIPE_STAGE_CHAIN_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count cycles in which a live result is held at the output by a stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (stall_i && valid_o && !flush_i && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_chain                                          |
// | Description : Self-checking bench for pipe_stage_chain. Two instances      |
// |               share stimulus: dut_a (STAGES=2, no collapse) and dut_b      |
// |               (STAGES=3, collapse). A slot-level reference model predicts  |
// |               ready_o and the output stage for both.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_chain;

    logic        clk = 1'b0;
    logic        rst, valid_in, stall, flush;
    logic [31:0] payload_in;
    logic [3:0]  ctrl_in;

    logic        a_ready, a_valid, b_ready, b_valid;
    logic [31:0] a_payload, b_payload;
    logic [3:0]  a_ctrl, b_ctrl;

    always #5 clk = ~clk;

`ifdef PIPE_STAGE_CHAIN_STALL_CNT_EN
    logic [15:0] a_cnt, b_cnt;
    logic [15:0] obs_cnt [2];
    assign obs_cnt[0] = a_cnt;
    assign obs_cnt[1] = b_cnt;
`endif

    pipe_stage_chain #(.PAYLOAD_W(32), .CTRL_W(4), .STAGES(2), .COLLAPSE(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .payload_i(payload_in),
        .ctrl_i(ctrl_in), .stall_i(stall), .flush_i(flush), .ready_o(a_ready),
        .valid_o(a_valid), .payload_o(a_payload),
`ifdef PIPE_STAGE_CHAIN_STALL_CNT_EN
        .stall_cnt_o(a_cnt),
`endif
        .ctrl_o(a_ctrl)
    );

    pipe_stage_chain #(.PAYLOAD_W(32), .CTRL_W(4), .STAGES(3), .COLLAPSE(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .payload_i(payload_in),
        .ctrl_i(ctrl_in), .stall_i(stall), .flush_i(flush), .ready_o(b_ready),
        .valid_o(b_valid), .payload_o(b_payload),
`ifdef PIPE_STAGE_CHAIN_STALL_CNT_EN
        .stall_cnt_o(b_cnt),
`endif
        .ctrl_o(b_ctrl)
    );

    logic        obs_ready   [2];
    logic        obs_valid   [2];
    logic [31:0] obs_payload [2];
    logic [3:0]  obs_ctrl    [2];
    assign obs_ready[0] = a_ready;   assign obs_ready[1] = b_ready;
    assign obs_valid[0] = a_valid;   assign obs_valid[1] = b_valid;
    assign obs_payload[0] = a_payload; assign obs_payload[1] = b_payload;
    assign obs_ctrl[0] = a_ctrl;     assign obs_ctrl[1] = b_ctrl;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: slot contents per instance, slot s-1 is the output.
    bit          m_v [2][4];
    logic [31:0] m_p [2][4];
    logic [3:0]  m_c [2][4];
    int unsigned m_cnt [2];

    typedef struct packed {
        logic        r;
        logic        v;
        logic [31:0] p;
        logic [3:0]  c;
        logic        st;
        logic        fl;
    } stim_t;

    function automatic int stages_of(int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic bit collapse_of(int d);
        return (d != 0);
    endfunction

    function automatic stim_t mk(bit r, bit v, logic [31:0] p, logic [3:0] c, bit st, bit fl);
        stim_t s;
        s.r = r; s.v = v; s.p = p; s.c = c; s.st = st; s.fl = fl;
        return s;
    endfunction

    // Input is accepted when not flushing and either nothing is stalled or,
    // in collapse mode, some non-output slot is empty and can absorb a shift.
    function automatic bit model_ready(int d);
        int s = stages_of(d);
        if (flush) return 1'b0;
        if (!stall) return 1'b1;
        if (collapse_of(d))
            for (int k = 0; k < s - 1; k++)
                if (!m_v[d][k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int s = stages_of(d);
            int top;
            if (rst) m_cnt[d] = 0;
            else if (stall && m_v[d][s-1] && !flush && m_cnt[d] != 32'hFFFF) m_cnt[d]++;
            if (rst) begin
                for (int k = 0; k < 4; k++) begin
                    m_v[d][k] = 1'b0; m_p[d][k] = '0; m_c[d][k] = '0;
                end
            end else if (flush) begin
                for (int k = 0; k < 4; k++) begin
                    m_v[d][k] = 1'b0; m_c[d][k] = '0;
                end
            end else begin
                // top = highest slot that shifts this edge; -1 means frozen.
                top = -1;
                if (!stall) top = s - 1;
                else if (collapse_of(d))
                    for (int k = 0; k < s - 1; k++)
                        if (!m_v[d][k]) top = k;
                for (int k = top; k >= 1; k--) begin
                    m_v[d][k] = m_v[d][k-1]; m_p[d][k] = m_p[d][k-1]; m_c[d][k] = m_c[d][k-1];
                end
                if (top >= 0) begin
                    m_v[d][0] = valid_in;
                    m_p[d][0] = payload_in;
                    m_c[d][0] = valid_in ? ctrl_in : 4'h0;
                end
            end
        end
    endtask

    task automatic apply(stim_t s);
        rst = s.r; valid_in = s.v; payload_in = s.p; ctrl_in = s.c;
        stall = s.st; flush = s.fl;
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        apply(mk(1, 1, 32'hFFFF_FFFF, 4'hF, 1, 1));
        advance();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_valid[d] !== 1'b0) $display("FAIL reset valid_o dut%0d: got %b want 0", d, obs_valid[d]);
            else n_pass++;
            n_checks++;
            if (obs_payload[d] !== 32'h0) $display("FAIL reset payload_o dut%0d: got %h want 0", d, obs_payload[d]);
            else n_pass++;
            n_checks++;
            if (obs_ctrl[d] !== 4'h0) $display("FAIL reset ctrl_o dut%0d: got %h want 0", d, obs_ctrl[d]);
            else n_pass++;
        end
    endtask

    task automatic test_latency();
        stim_t q[$];
        q.push_back(mk(1, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 1, 32'hA5A5_0001, 4'b1010, 0, 0));
        repeat (3) q.push_back(mk(0, 0, $urandom, 4'($urandom), 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            #1;
            for (int d = 0; d < 2; d++) if (!q[i].r) begin
                n_checks++;
                if (obs_ready[d] !== model_ready(d)) $display("FAIL latency ready dut%0d step %0d: got %b want %b", d, i, obs_ready[d], model_ready(d));
                else n_pass++;
            end
            advance();
            for (int d = 0; d < 2; d++) begin
                int s = stages_of(d);
                n_checks++;
                if ({obs_valid[d], obs_payload[d], obs_ctrl[d]} !== {m_v[d][s-1], m_p[d][s-1], m_v[d][s-1] ? m_c[d][s-1] : 4'h0})
                    $display("FAIL latency out dut%0d step %0d: got v=%b p=%h c=%h want v=%b p=%h c=%h", d, i, obs_valid[d], obs_payload[d], obs_ctrl[d], m_v[d][s-1], m_p[d][s-1], m_c[d][s-1]);
                else n_pass++;
            end
            if (i == 2) begin
                n_checks++;
                if ({a_valid, a_payload, a_ctrl} !== {1'b1, 32'hA5A5_0001, 4'b1010})
                    $display("FAIL latency arrive: got v=%b p=%h c=%h want v=1 p=a5a50001 c=a", a_valid, a_payload, a_ctrl);
                else n_pass++;
            end
            if (i == 3) begin
                n_checks++;
                if (a_valid !== 1'b0) $display("FAIL latency drain: got v=%b want 0", a_valid);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall_hold();
        stim_t q[$];
        q.push_back(mk(1, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 1, 32'd1, 4'h1, 0, 0));
        q.push_back(mk(0, 1, 32'd2, 4'h2, 0, 0));
        repeat (3) q.push_back(mk(0, 1, 32'd3, 4'h3, 1, 0));
        q.push_back(mk(0, 1, 32'd3, 4'h3, 0, 0));
        q.push_back(mk(0, 0, 32'd0, 4'h0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            #1;
            for (int d = 0; d < 2; d++) if (!q[i].r) begin
                n_checks++;
                if (obs_ready[d] !== model_ready(d)) $display("FAIL stall ready dut%0d step %0d: got %b want %b", d, i, obs_ready[d], model_ready(d));
                else n_pass++;
            end
            if (i >= 3 && i <= 5) begin
                n_checks++;
                if (a_ready !== 1'b0) $display("FAIL stall ready_a step %0d: got %b want 0", i, a_ready);
                else n_pass++;
            end
            advance();
            for (int d = 0; d < 2; d++) begin
                int s = stages_of(d);
                n_checks++;
                if ({obs_valid[d], obs_payload[d], obs_ctrl[d]} !== {m_v[d][s-1], m_p[d][s-1], m_v[d][s-1] ? m_c[d][s-1] : 4'h0})
                    $display("FAIL stall out dut%0d step %0d: got v=%b p=%h c=%h want v=%b p=%h c=%h", d, i, obs_valid[d], obs_payload[d], obs_ctrl[d], m_v[d][s-1], m_p[d][s-1], m_c[d][s-1]);
                else n_pass++;
            end
            if (i >= 2) begin
                logic [31:0] want;
                want = (i <= 5) ? 32'd1 : ((i == 6) ? 32'd2 : 32'd3);
                n_checks++;
                if (a_valid !== 1'b1 || a_payload !== want)
                    $display("FAIL stall sequence step %0d: got v=%b p=%h want v=1 p=%h", i, a_valid, a_payload, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_collapse();
        stim_t q[$];
        q.push_back(mk(1, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 1, 32'd5, 4'h5, 0, 0));
        q.push_back(mk(0, 0, 32'd0, 4'hF, 0, 0));
        q.push_back(mk(0, 1, 32'd7, 4'h7, 0, 0));
        q.push_back(mk(0, 1, 32'd9, 4'h9, 1, 0));
        repeat (3) q.push_back(mk(0, 0, 32'd0, 4'h0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            #1;
            for (int d = 0; d < 2; d++) if (!q[i].r) begin
                n_checks++;
                if (obs_ready[d] !== model_ready(d)) $display("FAIL collapse ready dut%0d step %0d: got %b want %b", d, i, obs_ready[d], model_ready(d));
                else n_pass++;
            end
            if (i == 4) begin
                n_checks++;
                if (b_ready !== 1'b1) $display("FAIL collapse ready_b: got %b want 1", b_ready);
                else n_pass++;
            end
            advance();
            for (int d = 0; d < 2; d++) begin
                int s = stages_of(d);
                n_checks++;
                if ({obs_valid[d], obs_payload[d], obs_ctrl[d]} !== {m_v[d][s-1], m_p[d][s-1], m_v[d][s-1] ? m_c[d][s-1] : 4'h0})
                    $display("FAIL collapse out dut%0d step %0d: got v=%b p=%h c=%h want v=%b p=%h c=%h", d, i, obs_valid[d], obs_payload[d], obs_ctrl[d], m_v[d][s-1], m_p[d][s-1], m_c[d][s-1]);
                else n_pass++;
            end
            if (i >= 4 && i <= 6) begin
                logic [31:0] want;
                want = (i == 4) ? 32'd5 : ((i == 5) ? 32'd7 : 32'd9);
                n_checks++;
                if (b_valid !== 1'b1 || b_payload !== want)
                    $display("FAIL collapse sequence step %0d: got v=%b p=%h want v=1 p=%h", i, b_valid, b_payload, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_flush();
        stim_t q[$];
        q.push_back(mk(1, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 1, 32'd11, 4'hB, 0, 0));
        q.push_back(mk(0, 1, 32'd12, 4'hC, 0, 0));
        q.push_back(mk(0, 1, 32'd13, 4'hD, 1, 1));
        q.push_back(mk(0, 0, 32'd0, 4'h0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            #1;
            for (int d = 0; d < 2; d++) if (!q[i].r) begin
                n_checks++;
                if (obs_ready[d] !== model_ready(d)) $display("FAIL flush ready dut%0d step %0d: got %b want %b", d, i, obs_ready[d], model_ready(d));
                else n_pass++;
            end
            if (i == 3) begin
                n_checks++;
                if (a_ready !== 1'b0) $display("FAIL flush ready_a: got %b want 0", a_ready);
                else n_pass++;
            end
            advance();
            for (int d = 0; d < 2; d++) begin
                int s = stages_of(d);
                n_checks++;
                if ({obs_valid[d], obs_payload[d], obs_ctrl[d]} !== {m_v[d][s-1], m_p[d][s-1], m_v[d][s-1] ? m_c[d][s-1] : 4'h0})
                    $display("FAIL flush out dut%0d step %0d: got v=%b p=%h c=%h want v=%b p=%h c=%h", d, i, obs_valid[d], obs_payload[d], obs_ctrl[d], m_v[d][s-1], m_p[d][s-1], m_c[d][s-1]);
                else n_pass++;
            end
            if (i >= 3) begin
                n_checks++;
                if (a_valid !== 1'b0 || a_ctrl !== 4'h0)
                    $display("FAIL flush squash step %0d: got v=%b c=%h want v=0 c=0", i, a_valid, a_ctrl);
                else n_pass++;
            end
        end
    endtask

    task automatic test_mid_reset();
        stim_t q[$];
        q.push_back(mk(1, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 1, 32'd21, 4'h1, 0, 0));
        q.push_back(mk(0, 1, 32'd22, 4'h2, 0, 0));
        q.push_back(mk(1, 1, 32'd23, 4'h3, 1, 1));
        q.push_back(mk(0, 1, 32'h77, 4'h5, 0, 0));
        repeat (3) q.push_back(mk(0, 0, 32'd0, 4'h0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            #1;
            for (int d = 0; d < 2; d++) if (!q[i].r) begin
                n_checks++;
                if (obs_ready[d] !== model_ready(d)) $display("FAIL midreset ready dut%0d step %0d: got %b want %b", d, i, obs_ready[d], model_ready(d));
                else n_pass++;
            end
            advance();
            for (int d = 0; d < 2; d++) begin
                int s = stages_of(d);
                n_checks++;
                if ({obs_valid[d], obs_payload[d], obs_ctrl[d]} !== {m_v[d][s-1], m_p[d][s-1], m_v[d][s-1] ? m_c[d][s-1] : 4'h0})
                    $display("FAIL midreset out dut%0d step %0d: got v=%b p=%h c=%h want v=%b p=%h c=%h", d, i, obs_valid[d], obs_payload[d], obs_ctrl[d], m_v[d][s-1], m_p[d][s-1], m_c[d][s-1]);
                else n_pass++;
            end
            if (i == 3) begin
                n_checks++;
                if ({a_valid, a_payload, a_ctrl} !== 37'h0)
                    $display("FAIL midreset clear: got v=%b p=%h c=%h want all 0", a_valid, a_payload, a_ctrl);
                else n_pass++;
            end
            if (i == 5 || i == 6) begin
                n_checks++;
                if (((i == 5) ? {a_valid, a_payload} : {b_valid, b_payload}) !== {1'b1, 32'h77})
                    $display("FAIL midreset recapture step %0d: got a=%b/%h b=%b/%h want v=1 p=77", i, a_valid, a_payload, b_valid, b_payload);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        stim_t q[$];
        for (int i = 0; i < 400; i++)
            q.push_back(mk($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom,
                            4'($urandom), $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0));
        foreach (q[i]) begin
            apply(q[i]);
            #1;
            for (int d = 0; d < 2; d++) if (!q[i].r) begin
                n_checks++;
                if (obs_ready[d] !== model_ready(d)) $display("FAIL random ready dut%0d step %0d: got %b want %b", d, i, obs_ready[d], model_ready(d));
                else n_pass++;
            end
            advance();
            for (int d = 0; d < 2; d++) begin
                int s = stages_of(d);
                n_checks++;
                if ({obs_valid[d], obs_payload[d], obs_ctrl[d]} !== {m_v[d][s-1], m_p[d][s-1], m_v[d][s-1] ? m_c[d][s-1] : 4'h0})
                    $display("FAIL random out dut%0d step %0d: got v=%b p=%h c=%h want v=%b p=%h c=%h", d, i, obs_valid[d], obs_payload[d], obs_ctrl[d], m_v[d][s-1], m_p[d][s-1], m_c[d][s-1]);
                else n_pass++;
`ifdef PIPE_STAGE_CHAIN_STALL_CNT_EN
                n_checks++;
                if (obs_cnt[d] !== 16'(m_cnt[d])) $display("FAIL random stall_cnt dut%0d step %0d: got %h want %h", d, i, obs_cnt[d], 16'(m_cnt[d]));
                else n_pass++;
`endif
            end
        end
    endtask

`ifdef PIPE_STAGE_CHAIN_STALL_CNT_EN
    task automatic test_stall_cnt();
        stim_t q[$];
        q.push_back(mk(1, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 1, 32'd1, 4'h1, 0, 0));
        q.push_back(mk(0, 1, 32'd2, 4'h2, 0, 0));
        repeat (5) q.push_back(mk(0, 0, 32'd0, 4'h0, 1, 0));
        q.push_back(mk(0, 0, 32'd0, 4'h0, 1, 1));
        repeat (2) q.push_back(mk(0, 0, 32'd0, 4'h0, 1, 0));
        q.push_back(mk(0, 1, 32'd3, 4'h3, 0, 0));
        q.push_back(mk(0, 1, 32'd4, 4'h4, 0, 0));
        repeat (5) q.push_back(mk(0, 0, 32'd0, 4'h0, 1, 0));
        foreach (q[i]) begin
            if (i == 13) begin
                dut_a.r_stall_cnt = 16'hFFFD;
                m_cnt[0] = 32'hFFFD;
            end
            apply(q[i]);
            advance();
            n_checks++;
            if (a_cnt !== 16'(m_cnt[0])) $display("FAIL stall_cnt step %0d: got %h want %h", i, a_cnt, 16'(m_cnt[0]));
            else n_pass++;
            if (i == 10 || i == 17) begin
                n_checks++;
                if (a_cnt !== ((i == 10) ? 16'd5 : 16'hFFFF))
                    $display("FAIL stall_cnt value step %0d: got %h want %h", i, a_cnt, (i == 10) ? 16'd5 : 16'hFFFF);
                else n_pass++;
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; valid_in = 1'b0; payload_in = '0; ctrl_in = '0;
        stall = 1'b0; flush = 1'b0;
        test_reset();
        test_latency();
        test_stall_hold();
        test_collapse();
        test_flush();
        test_mid_reset();
        test_random();
`ifdef PIPE_STAGE_CHAIN_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
